// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial-bit link transmitter.
package serial_tx_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned DEFAULT_DIV   = 100_000_000;
  localparam int unsigned IDX_W         = 4;

  // Transmitter states; encoding is visible to the lab debug display.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // One-clock history of the debounced button levels.
  typedef struct packed {
    logic step;
    logic load;
  } btn_hist_t;

endpackage

// File: rtl/serial_tx_tick_gen.sv
// Step divider: counts enabled cycles and pulses tick when it wraps at DIV-1.
module serial_tx_tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = (cnt_q == CW'(DIV - 1));
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en & wrap;

endmodule

// File: rtl/serial_tx.sv
// Parallel-in/serial-out pattern transmitter for the lab serial-bit link.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DIV       = DEFAULT_DIV,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             load,
  input  logic             auto,
  input  logic             loop,
  input  logic [WIDTH-1:0] pattern,
  output logic             dout,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] bit_idx,
  output logic [WIDTH-1:0] sreg
);

  state_e           state_q, state_d;
  btn_hist_t        hist_q;
  logic             dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] saved_q, saved_d;

  logic ld_e;
  logic st_e;
  logic tick;
  logic step_ev;
  logic load_ok;
  logic div_en;

  // Bit at the send end of a register image.
  function automatic logic send_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  // Move the register one place toward the send end, zero-filling behind.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign ld_e    = load & ~hist_q.load;
  assign st_e    = step & ~hist_q.step;
  assign step_ev = auto ? tick : st_e;
  assign load_ok = ld_e & (state_q != ST_SHIFT);
  assign div_en  = (state_q == ST_SHIFT);

  serial_tx_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (div_en),
    .clr  (load_ok),
    .tick (tick)
  );

  // Button history; reset copies live levels so a held button gives no edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q.step <= step;
      hist_q.load <= load;
    end else begin
      hist_q.step <= step;
      hist_q.load <= load;
    end
  end

  // Next-state and datapath: load starts a transfer, step events walk the bits.
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    bit_idx_d = bit_idx_q;
    sreg_d    = sreg_q;
    saved_d   = saved_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Load wins over a coincident step; steps alone do nothing here.
        if (ld_e) begin
          state_d   = ST_SHIFT;
          saved_d   = pattern;
          sreg_d    = pattern;
          bit_idx_d = '0;
          dout_d    = send_bit(pattern);
        end
      end
      ST_SHIFT: begin
        if (step_ev) begin
          if (bit_idx_q != IDX_W'(WIDTH - 1)) begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            sreg_d    = shift_once(sreg_q);
            dout_d    = send_bit(shift_once(sreg_q));
          end else if (loop) begin
            bit_idx_d = '0;
            sreg_d    = saved_q;
            dout_d    = send_bit(saved_q);
          end else begin
            state_d = ST_DONE;
            dout_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_idx_q <= '0;
      sreg_q    <= '0;
      saved_q   <= '0;
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bit_idx_q <= bit_idx_d;
      sreg_q    <= sreg_d;
      saved_q   <= saved_d;
    end
  end

  assign dout    = dout_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = bit_idx_q;
  assign sreg    = sreg_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: directed link scenarios plus random button traffic,
// both bit orders side by side, against a transfer-level reference model.
module tb_serial_tx;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         step;
  logic         load;
  logic         auto_s;
  logic         loop_s;
  logic [W-1:0] pattern;

  logic         dout_m, busy_m, done_m;
  logic [3:0]   idx_m;
  logic [W-1:0] sreg_m;
  logic         dout_l, busy_l, done_l;
  logic [3:0]   idx_l;
  logic [W-1:0] sreg_l;

  int checks   = 0;
  int failures = 0;

  // Model: 0 idle, 1 sending, 2 finished; position within the saved pattern.
  int           m_state = 0;
  int           m_idx   = 0;
  int           m_cnt   = 0;
  logic [W-1:0] m_saved = '0;
  logic         m_step_p = 1'b0;
  logic         m_load_p = 1'b0;

  always #5 clk = ~clk;

  serial_tx #(.WIDTH(W), .DIV(D), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .step(step), .load(load), .auto(auto_s), .loop(loop_s),
    .pattern(pattern), .dout(dout_m), .busy(busy_m), .done(done_m),
    .bit_idx(idx_m), .sreg(sreg_m)
  );

  serial_tx #(.WIDTH(W), .DIV(D), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .step(step), .load(load), .auto(auto_s), .loop(loop_s),
    .pattern(pattern), .dout(dout_l), .busy(busy_l), .done(done_l),
    .bit_idx(idx_l), .sreg(sreg_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Expected dout: the pattern bit at the current position, counted from the send end.
  function automatic logic exp_dout(input bit msb);
    if (m_state != 1) return 1'b0;
    return msb ? m_saved[W-1-m_idx] : m_saved[m_idx];
  endfunction

  // Expected register: saved pattern with m_idx bits already sent off the end.
  function automatic logic [W-1:0] exp_sreg(input bit msb);
    if (m_state == 0) return '0;
    return msb ? W'(m_saved << m_idx) : W'(m_saved >> m_idx);
  endfunction

  // Apply one clock edge of the transfer rules to the model using current inputs.
  task automatic model_step();
    bit ld_e, st_e, tick, ev;
    if (!rst) begin
      m_state = 0; m_idx = 0; m_cnt = 0; m_saved = '0;
    end else begin
      ld_e = load && !m_load_p;
      st_e = step && !m_step_p;
      tick = (m_state == 1) && (m_cnt == D - 1);
      ev   = auto_s ? tick : st_e;
      if (m_state != 1) begin
        if (ld_e) begin
          m_state = 1; m_saved = pattern; m_idx = 0; m_cnt = 0;
        end
      end else begin
        m_cnt = (m_cnt + 1) % D;
        if (ev) begin
          if (m_idx < W - 1) m_idx++;
          else if (loop_s)   m_idx = 0;
          else               m_state = 2;
        end
      end
    end
    m_step_p = step;
    m_load_p = load;
  endtask

  task automatic check_outputs();
    check_eq("dout_msb", 32'(dout_m), 32'(exp_dout(1'b1)));
    check_eq("dout_lsb", 32'(dout_l), 32'(exp_dout(1'b0)));
    check_eq("busy_msb", 32'(busy_m), 32'(m_state == 1));
    check_eq("busy_lsb", 32'(busy_l), 32'(m_state == 1));
    check_eq("done_msb", 32'(done_m), 32'(m_state == 2));
    check_eq("done_lsb", 32'(done_l), 32'(m_state == 2));
    check_eq("idx_msb",  32'(idx_m),  32'(m_idx));
    check_eq("idx_lsb",  32'(idx_l),  32'(m_idx));
    check_eq("sreg_msb", 32'(sreg_m), 32'(exp_sreg(1'b1)));
    check_eq("sreg_lsb", 32'(sreg_l), 32'(exp_sreg(1'b0)));
  endtask

  // One clock: model the edge, let the DUT take it, compare just after.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic pulse_load(input logic [W-1:0] pat);
    pattern = pat;
    load = 1'b1; cyc();
    load = 1'b0; cyc();
  endtask

  task automatic pulse_step();
    step = 1'b1; cyc();
    step = 1'b0; cyc();
  endtask

  initial begin
    logic [7:0] seq;
    rst = 1'b0; step = 1'b1; load = 1'b1; auto_s = 1'b0; loop_s = 1'b0; pattern = '0;
    #1;

    // Reset with both buttons held; release must not start a transfer.
    cyc(); cyc();
    check_eq("t1_rst_busy", 32'(busy_m), 32'd0);
    check_eq("t1_rst_dout", 32'(dout_m), 32'd0);
    check_eq("t1_rst_sreg", 32'(sreg_m), 32'd0);
    rst = 1'b1;
    repeat (3) cyc();
    check_eq("t1_held_busy", 32'(busy_m), 32'd0);
    check_eq("t1_held_idx",  32'(idx_m),  32'd0);
    step = 1'b0; load = 1'b0; cyc();

    // Manual MSB-first transfer of 1011_0010.
    pulse_load(8'b1011_0010);
    seq[7] = dout_m;
    for (int i = 1; i < 8; i++) begin
      pulse_step();
      seq[7-i] = dout_m;
      check_eq("t2_idx", 32'(idx_m), 32'(i));
    end
    check_eq("t2_seq", 32'(seq), 32'h0000_00B2);
    pulse_step();
    check_eq("t2_done", 32'(done_m), 32'd1);
    check_eq("t2_busy", 32'(busy_m), 32'd0);
    check_eq("t2_dout", 32'(dout_m), 32'd0);
    check_eq("t2_hold_idx", 32'(idx_m), 32'd7);

    // Load and step edges together in DONE: load wins.
    pattern = 8'h01; load = 1'b1; step = 1'b1; cyc();
    check_eq("t5_busy", 32'(busy_m), 32'd1);
    check_eq("t5_idx",  32'(idx_m),  32'd0);
    check_eq("t5_dout_msb", 32'(dout_m), 32'd0);
    check_eq("t5_dout_lsb", 32'(dout_l), 32'd1);
    load = 1'b0; step = 1'b0; cyc();

    // LSB-first sequence of 8'h01.
    seq[7] = dout_l;
    for (int i = 1; i < 8; i++) begin
      pulse_step();
      seq[7-i] = dout_l;
    end
    check_eq("t6_seq", 32'(seq), 32'h0000_0080);
    pulse_step();
    check_eq("t6_done", 32'(done_l), 32'd1);

    // Auto stepping with loop: one bit per D clocks, wrap after the last bit.
    auto_s = 1'b1; loop_s = 1'b1;
    pulse_load(8'hA5);
    repeat (2) cyc();
    check_eq("t3_first_hold", 32'(idx_m), 32'd0);
    cyc();
    check_eq("t3_first_step", 32'(idx_m), 32'd1);
    repeat (27) cyc();
    check_eq("t3_last_idx",  32'(idx_m),  32'd7);
    check_eq("t3_last_dout", 32'(dout_m), 32'd1);
    cyc();
    check_eq("t3_wrap_idx",  32'(idx_m),  32'd0);
    check_eq("t3_wrap_dout", 32'(dout_m), 32'd1);
    check_eq("t3_wrap_busy", 32'(busy_m), 32'd1);

    // Load ignored while sending; reset aborts mid-transfer.
    auto_s = 1'b0; loop_s = 1'b0;
    rst = 1'b0; cyc(); rst = 1'b1; cyc();
    pulse_load(8'h3C);
    repeat (3) pulse_step();
    check_eq("t4_idx", 32'(idx_m), 32'd3);
    pulse_load(8'hFF);
    check_eq("t4_ign_idx",  32'(idx_m),  32'd3);
    check_eq("t4_ign_dout", 32'(dout_m), 32'd1);
    check_eq("t4_ign_sreg", 32'(sreg_m), 32'h0000_00E0);
    rst = 1'b0; cyc();
    check_eq("t4_rst_busy", 32'(busy_m), 32'd0);
    check_eq("t4_rst_dout", 32'(dout_m), 32'd0);
    check_eq("t4_rst_idx",  32'(idx_m),  32'd0);
    rst = 1'b1; cyc();

    // Random button traffic, mode changes and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 2) == 0)   step   = ~step;
      if ($urandom_range(0, 11) == 0)  load   = ~load;
      if ($urandom_range(0, 149) == 0) auto_s = ~auto_s;
      if ($urandom_range(0, 99) == 0)  loop_s = ~loop_s;
      pattern = W'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
